microc_call_dp: RTL and testbench
=================================

Name: microc_call_dp

Overview:
- Parametrised single-cycle microcontroller datapath: PC, 16-entry register file, ALU, zero and carry flags, hardware return-address stack for CALL/RET.
- Controlled by an external control unit through decoded strobes; fetches from an external program memory through `pc` and `instr`.
- Successor to the 8-bit fixed datapath. Adds data-width and PC-width generality, a carry flag and subroutine support with stack-fault detection.

Parameters:
- DW, 8, data/register width; must be ≥8.
- PCW, 10, PC width; must be ≤10; jump target is instr[PCW-1:0].
- STACK_DEPTH, 4, return-address stack entries; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  16  instruction word from program memory for the current `pc`.
- s_inc  in  1  1 = sequential PC (pc+1), 0 = jump/call to instr[PCW-1:0].
- s_inm  in  1  1 = ALU operand A is the immediate, 0 = A is rd1.
- we3  in  1  register-file write enable.
- wez  in  1  zero-flag write enable.
- wec  in  1  carry-flag write enable.
- op  in  3  ALU operation.
- push  in  1  CALL: push return address pc+1.
- pop  in  1  RET: load PC from stack top.
- pc  out  PCW  current program counter.
- opcode  out  6  instr[15:10].
- z  out  1  zero flag.
- c  out  1  carry/borrow flag.
- stack_full  out  1  stack count == STACK_DEPTH.
- stack_empty  out  1  stack count == 0.
- stack_err  out  1  sticky stack-fault flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0, z=0, c=0, stack_err=0, stack count=0, all registers=0.
  - Reset asserted mid-program discards stack contents.
- Instruction fields:
  - RA1=instr[11:8], RA2=instr[7:4], WA3=instr[3:0].
  - Immediate = instr[11:4], zero-extended to DW.
  - With s_inm=1, the RA2 read address is replaced by instr[3:0].
- Register file:
  - Reads are combinational.
  - Write happens on the rising edge when we3=1. WA3=0 writes are discarded; r0 always reads 0.
  - Read-during-write returns the old value.
- ALU operands: A = s_inm ? imm : rd1, B = rd2. Result width is DW and is written to WA3.
- ALU operations:
  - op 000 A; 001 ~A; 010 A+B; 011 A−B; 100 A&B; 101 A|B; 110 −A; 111 −B.
  - Carry: carry-out for 010; borrow (A<B unsigned) for 011; 0 for all other ops.
- Flags:
  - z ← (result==0) on the edge when wez=1.
  - c ← carry on the edge when wec=1.
  - Otherwise each flag holds.
- Next PC, all arithmetic modulo 2^PCW, evaluated in this priority:
  1. push=1 and pop=1: no stack change; pc ← pc+1; stack_err ← 1.
  2. pop=1, stack not empty: pc ← top; count−1.
  3. pop=1, stack empty: pc ← pc+1; stack_err ← 1.
  4. push=1: if not full, push pc+1 and count+1. If full, no push and stack_err ← 1. In both cases pc follows s_inc (a CALL normally has s_inc=0).
  5. Otherwise: pc ← s_inc ? pc+1 : instr[PCW-1:0].
- Stack:
  - LIFO; the stored value is pc+1 of the CALL, wrapped at 2^PCW.
  - stack_full and stack_empty are combinational from the count.
  - stack_err clears only on reset.
- All state updates occur on one edge; every instruction has single-cycle latency.

Test Plan:
- Reset then 3 cycles with s_inc=1 → pc 0,1,2,3; z=c=0; stack_empty=1.
- DW=8, imm 0xF0 → r1 and imm 0x20 → r2; op=010 with we3, wez, wec, writing r3 → r3=0x10, c=1, z=0. Then op=011 with r2, r1 → c=1 (0x20<0xF0).
- At pc=5, push with s_inc=0 and target 0x40 → pc=0x40, count=1. At pc=0x41, pop → pc=6, stack_empty=1, stack_err=0.
- STACK_DEPTH=4: five nested CALLs → stack_full=1 after the 4th; the 5th still jumps and sets stack_err=1. Four RETs then return in LIFO order.
- pop while empty at pc=0x3FF (PCW=10) → pc=0x000, stack_err=1. Sticky across 10 further cycles until reset.
- Assert reset during a write cycle with push → asynchronous clear: pc=0, stack empty, write lost. Also check a write to r0 leaves r0=0.

Source files
------------

// File: rtl/microc_call_dp_if.sv
// microc_call_dp_if: control/fetch bundle between control unit, program memory and datapath
interface microc_call_dp_if #(
  parameter int PCW = 10
);
  logic [15:0] instr;
  logic s_inc, s_inm, we3, wez, wec, push, pop;
  logic [2:0] op;
  logic [PCW-1:0] pc;
  logic [5:0] opcode;
  logic z, c, stack_full, stack_empty, stack_err;
  modport master (
    output instr, s_inc, s_inm, we3, wez, wec, op, push, pop,
    input pc, opcode, z, c, stack_full, stack_empty, stack_err
  );
  modport slave (
    input instr, s_inc, s_inm, we3, wez, wec, op, push, pop,
    output pc, opcode, z, c, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/microc_call_dp.sv
// microc_call_dp: single-cycle microcontroller datapath with return-address stack
module microc_call_dp #(
  parameter int DW = 8,
  parameter int PCW = 10,
  parameter int STACK_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  microc_call_dp_if.slave bus
);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);
  logic [PCW-1:0] pc_q, pc_d, pc_inc;
  logic [PCW-1:0] stack_q [STACK_DEPTH];
  logic [SW-1:0] cnt_q, cnt_d;
  logic z_q, z_d, c_q, c_d, err_q, err_d, do_push, full, empty, alu_c;
  logic [DW-1:0] rf_q [16];
  logic [DW-1:0] a, b, res;
  logic [DW:0] sum, diff;
  logic [3:0] ra2, wa3;
  assign wa3 = bus.instr[3:0];
  assign ra2 = bus.s_inm ? wa3 : bus.instr[7:4];
  assign a = bus.s_inm ? DW'(bus.instr[11:4]) : rf_q[bus.instr[11:8]];
  assign b = rf_q[ra2];
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign res = bus.op == 3'd0 ? a :
               bus.op == 3'd1 ? ~a :
               bus.op == 3'd2 ? sum[DW-1:0] :
               bus.op == 3'd3 ? diff[DW-1:0] :
               bus.op == 3'd4 ? a & b :
               bus.op == 3'd5 ? a | b :
               bus.op == 3'd6 ? -a : -b;
  assign alu_c = bus.op == 3'd2 ? sum[DW] : bus.op == 3'd3 ? diff[DW] : 1'b0;
  assign pc_inc = pc_q + PCW'(1);
  assign full = cnt_q == SW'(STACK_DEPTH);
  assign empty = cnt_q == '0;
  always_comb begin
    pc_d = bus.s_inc ? pc_inc : bus.instr[PCW-1:0];
    cnt_d = cnt_q;
    err_d = err_q;
    do_push = 1'b0;
    z_d = bus.wez ? res == '0 : z_q;
    c_d = bus.wec ? alu_c : c_q;
    if (bus.push && bus.pop) begin
      pc_d = pc_inc;
      err_d = 1'b1;
    end else if (bus.pop) begin
      pc_d = empty ? pc_inc : stack_q[IW'(cnt_q - SW'(1))];
      cnt_d = empty ? cnt_q : cnt_q - SW'(1);
      err_d = err_q | empty;
    end else if (bus.push) begin
      do_push = !full;
      cnt_d = full ? cnt_q : cnt_q + SW'(1);
      err_d = err_q | full;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q <= '0;
      cnt_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      z_q <= z_d;
      c_q <= c_d;
      err_q <= err_d;
      if (bus.we3 && wa3 != 4'd0) rf_q[wa3] <= res;
    end
  always_ff @(posedge clk)
    if (do_push) stack_q[cnt_q[IW-1:0]] <= pc_inc;
  assign bus.pc = pc_q;
  assign bus.opcode = bus.instr[15:10];
  assign bus.z = z_q;
  assign bus.c = c_q;
  assign bus.stack_full = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err = err_q;
endmodule

// File: tb/tb_microc_call_dp.sv
// tb_microc_call_dp: directed vector bench for microc_call_dp
module tb_microc_call_dp;
  typedef struct {
    logic [15:0] instr;
    logic [9:0] ctl;
    logic [14:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  vec_t v [21];
  logic [14:0] st;
  microc_call_dp_if #(.PCW(10)) bus ();
  microc_call_dp #(.DW(8), .PCW(10), .STACK_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign st = {bus.pc, bus.z, bus.c, bus.stack_full, bus.stack_empty, bus.stack_err};
  task automatic apply(input logic [15:0] i, input logic [9:0] ctl);
    bus.instr = i;
    {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.wec, bus.op, bus.push, bus.pop} = ctl;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got pc=%h zcfer=%b, expected pc=%h zcfer=%b", nm, act[14:5], act[4:0], exp[14:5], exp[4:0]);
    end
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask
  initial begin
    v[0]  = '{16'h0000, 10'b1_0_0_0_0_000_0_0, {10'h001, 5'b00010}};
    v[1]  = '{16'h0000, 10'b1_0_0_0_0_000_0_0, {10'h002, 5'b00010}};
    v[2]  = '{16'h0000, 10'b1_0_0_0_0_000_0_0, {10'h003, 5'b00010}};
    v[3]  = '{16'h0F01, 10'b1_1_1_0_0_000_0_0, {10'h004, 5'b00010}};
    v[4]  = '{16'h0202, 10'b1_1_1_0_0_000_0_0, {10'h005, 5'b00010}};
    v[5]  = '{16'h0040, 10'b0_0_0_0_0_000_1_0, {10'h040, 5'b00000}};
    v[6]  = '{16'h0123, 10'b1_0_1_1_1_010_0_0, {10'h041, 5'b01000}};
    v[7]  = '{16'h0000, 10'b1_0_0_0_0_000_0_1, {10'h006, 5'b01010}};
    v[8]  = '{16'h0120, 10'b1_0_0_1_1_011_0_0, {10'h007, 5'b00010}};
    v[9]  = '{16'h0210, 10'b1_0_0_1_1_011_0_0, {10'h008, 5'b01010}};
    v[10] = '{16'h0103, 10'b1_1_0_1_1_011_0_0, {10'h009, 5'b10010}};
    v[11] = '{16'h0101, 10'b1_1_0_1_1_010_0_0, {10'h00A, 5'b11010}};
    v[12] = '{16'h00F1, 10'b1_1_0_1_1_100_0_0, {10'h00B, 5'b10010}};
    v[13] = '{16'h00F1, 10'b1_1_0_1_0_101_0_0, {10'h00C, 5'b00010}};
    v[14] = '{16'h0000, 10'b1_1_0_1_0_111_0_0, {10'h00D, 5'b10010}};
    v[15] = '{16'h0010, 10'b1_1_0_1_0_110_0_0, {10'h00E, 5'b00010}};
    v[16] = '{16'h0FF0, 10'b1_1_0_1_0_001_0_0, {10'h00F, 5'b10010}};
    v[17] = '{16'h0550, 10'b1_1_1_1_0_000_0_0, {10'h010, 5'b00010}};
    v[18] = '{16'h0000, 10'b1_0_0_1_0_000_0_0, {10'h011, 5'b10010}};
    v[19] = '{16'h03FF, 10'b0_0_0_0_0_000_0_0, {10'h3FF, 5'b10010}};
    v[20] = '{16'h0000, 10'b1_0_0_0_0_000_0_1, {10'h000, 5'b10011}};
    apply(16'h0000, 10'b1_0_0_0_0_000_0_0);
    #2;
    chk("reset_state", st, {10'h000, 5'b00010});
    #1;
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      apply(v[i].instr, v[i].ctl);
      cyc();
      chk($sformatf("vec%0d", i), st, v[i].exp);
    end
    apply(16'h0000, 10'b1_0_0_0_0_000_0_0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk($sformatf("err_sticky%0d", i), st, {10'(i), 5'b10011});
    end
    pulse_reset();
    chk("reset_clears_err", st, {10'h000, 5'b00010});
    for (int i = 0; i < 5; i++) begin
      apply(16'((i + 1) * 16), 10'b0_0_0_0_0_000_1_0);
      cyc();
      chk($sformatf("call%0d", i + 1), st, {10'((i + 1) * 16), 2'b00, i >= 3, 1'b0, i == 4});
    end
    for (int i = 0; i < 4; i++) begin
      apply(16'h0000, 10'b1_0_0_0_0_000_0_1);
      cyc();
      chk($sformatf("ret%0d", i + 1), st, {10'((3 - i) * 16 + 1), 3'b000, i == 3, 1'b1});
    end
    pulse_reset();
    apply(16'h0060, 10'b0_0_0_0_0_000_1_0);
    cyc();
    chk("call_before_pushpop", st, {10'h060, 5'b00000});
    apply(16'h0070, 10'b0_0_0_0_0_000_1_1);
    cyc();
    chk("push_and_pop", st, {10'h061, 5'b00001});
    apply(16'h0000, 10'b1_0_0_0_0_000_0_1);
    cyc();
    chk("ret_after_pushpop", st, {10'h001, 5'b00011});
    pulse_reset();
    apply(16'h0335, 10'b0_1_1_0_0_000_1_0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_now", st, {10'h000, 5'b00010});
    cyc();
    chk("reset_held_edge", st, {10'h000, 5'b00010});
    reset = 1'b1;
    apply(16'h0500, 10'b1_0_0_1_0_000_0_0);
    cyc();
    chk("write_lost_r5", st, {10'h001, 5'b10010});
    apply(16'hFC00, 10'b1_0_0_0_0_000_0_0);
    #1;
    chk("opcode", {9'd0, bus.opcode}, 15'h003F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
